// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding (MEM > WB > retired-writeback history > regfile)
// plus load-use hazard detection with a configurable stall length.

module hfu_src_fwd #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int HIST_DEPTH = 1,
    parameter int SEL_W      = 2
) (
    input  logic [REG_AW-1:0]                  src_addr,
    input  logic                               src_valid,
    input  logic [REG_AW-1:0]                  mem_dest,
    input  logic                               mem_load_regfile,
    input  logic [DATA_W-1:0]                  mem_data,
    input  logic [REG_AW-1:0]                  wb_dest,
    input  logic                               wb_load_regfile,
    input  logic [DATA_W-1:0]                  wb_data,
    input  logic [HIST_DEPTH-1:0]              hist_valid,
    input  logic [HIST_DEPTH-1:0][REG_AW-1:0]  hist_dest,
    input  logic [HIST_DEPTH-1:0][DATA_W-1:0]  hist_data,
    output logic [SEL_W-1:0]                   sel,
    output logic [DATA_W-1:0]                  data
);

    // Lowest priority is applied first so later, higher-priority hits overwrite it.
    always_comb begin
        sel  = '0;
        data = '0;
        if (src_valid) begin
            for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                if (hist_valid[k] && hist_dest[k] == src_addr) begin
                    sel  = SEL_W'(3 + k);
                    data = hist_data[k];
                end
            end
            if (wb_load_regfile && wb_dest == src_addr) begin
                sel  = SEL_W'(2);
                data = wb_data;
            end
            if (mem_load_regfile && mem_dest == src_addr) begin
                sel  = SEL_W'(1);
                data = mem_data;
            end
        end
    end

endmodule

module hazard_forward_unit #(
    parameter  int DATA_W     = 16,
    parameter  int REG_AW     = 3,
    parameter  int NUM_SRC    = 2,
    parameter  int HIST_DEPTH = 1,
    parameter  int LOAD_LAT   = 1,
    localparam int SEL_W      = $clog2(3 + HIST_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        stall_in,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]          id_src_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src_addr,
    input  logic [NUM_SRC-1:0]          ex_src_valid,
    input  logic [REG_AW-1:0]           ex_dest,
    input  logic                        ex_load_regfile,
    input  logic                        ex_is_load,
    input  logic [REG_AW-1:0]           mem_dest,
    input  logic                        mem_load_regfile,
    input  logic [DATA_W-1:0]           mem_data,
    input  logic [REG_AW-1:0]           wb_dest,
    input  logic                        wb_load_regfile,
    input  logic [DATA_W-1:0]           wb_data,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic                        load_use_stall,
    output logic                        bubble_ex
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } hist_t;

    typedef enum logic {IDLE, LU_STALL} state_t;

    hist_t [HIST_DEPTH-1:0]              hist;
    logic  [HIST_DEPTH-1:0]              hist_valid;
    logic  [HIST_DEPTH-1:0][REG_AW-1:0]  hist_dest;
    logic  [HIST_DEPTH-1:0][DATA_W-1:0]  hist_data;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, next_cnt;
    logic [NUM_SRC-1:0] id_match;
    logic               hazard;
    logic               stall_req;

    // History ages by cycle: an idle WB still pushes an invalid entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
        end else if (!stall_in) begin
            hist[0] <= '{valid: wb_load_regfile, dest: wb_dest, data: wb_data};
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    for (genvar h = 0; h < HIST_DEPTH; h++) begin : g_hist
        assign hist_valid[h] = hist[h].valid;
        assign hist_dest[h]  = hist[h].dest;
        assign hist_data[h]  = hist[h].data;
    end

    hfu_src_fwd #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .HIST_DEPTH (HIST_DEPTH),
        .SEL_W      (SEL_W)
    ) u_src [NUM_SRC-1:0] (
        .src_addr         (ex_src_addr),
        .src_valid        (ex_src_valid),
        .mem_dest         (mem_dest),
        .mem_load_regfile (mem_load_regfile),
        .mem_data         (mem_data),
        .wb_dest          (wb_dest),
        .wb_load_regfile  (wb_load_regfile),
        .wb_data          (wb_data),
        .hist_valid       (hist_valid),
        .hist_dest        (hist_dest),
        .hist_data        (hist_data),
        .sel              (fwd_sel),
        .data             (fwd_data)
    );

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_idm
        assign id_match[g] = id_src_valid[g] &&
                             (id_src_addr[g*REG_AW +: REG_AW] == ex_dest);
    end

    // Any number of matching sources collapses into a single stall episode.
    assign hazard = ex_is_load && ex_load_regfile && (|id_match);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall_req  = 1'b0;
        case (state)
            IDLE: begin
                if (hazard) begin
                    stall_req = 1'b1;
                    if (!stall_in && LOAD_LAT > 1) begin
                        next_state = LU_STALL;
                        next_cnt   = CNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            LU_STALL: begin
                stall_req = 1'b1;
                if (!stall_in) begin
                    if (cnt == CNT_W'(1)) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Held reset masks a live hazard so the front end is never frozen under reset.
    assign load_use_stall = reset_n & stall_req;
    assign bubble_ex      = reset_n & stall_req;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and random checks of hazard_forward_unit against a queue-based
// behavioural model of forwarding priority and load-use stall length.

module tb_hazard_forward_unit;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NS = 2;
    localparam int HD = 2;
    localparam int LL = 2;
    localparam int SW = $clog2(3 + HD);

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           stall_in;
    logic [NS*AW-1:0] id_src_addr, ex_src_addr;
    logic [NS-1:0]  id_src_valid, ex_src_valid;
    logic [AW-1:0]  ex_dest, mem_dest, wb_dest;
    logic           ex_load_regfile, ex_is_load, mem_load_regfile, wb_load_regfile;
    logic [DW-1:0]  mem_data, wb_data;
    logic [NS*SW-1:0] fwd_sel;
    logic [NS*DW-1:0] fwd_data;
    logic           load_use_stall, bubble_ex;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .HIST_DEPTH(HD), .LOAD_LAT(LL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
        .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .ex_src_addr(ex_src_addr), .ex_src_valid(ex_src_valid),
        .ex_dest(ex_dest), .ex_load_regfile(ex_load_regfile), .ex_is_load(ex_is_load),
        .mem_dest(mem_dest), .mem_load_regfile(mem_load_regfile), .mem_data(mem_data),
        .wb_dest(wb_dest), .wb_load_regfile(wb_load_regfile), .wb_data(wb_data),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data),
        .load_use_stall(load_use_stall), .bubble_ex(bubble_ex)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mh[$];      // mh[0] is the most recent retired writeback
    int   mbusy;      // stall cycles still owed after the detecting cycle
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        bit found = 1'b0;
        for (int i = 0; i < NS; i++)
            if (id_src_valid[i] && id_src_addr[i*AW +: AW] == ex_dest) found = 1'b1;
        return ex_is_load && ex_load_regfile && found;
    endfunction

    task automatic model_reset();
        mh = {};
        for (int k = 0; k < HD; k++) mh.push_back('{1'b0, '0, '0});
        mbusy = 0;
    endtask

    task automatic model_check();
        bit st;
        st = reset_n && (mbusy > 0 || model_hazard());
        chk("load_use_stall", 32'(load_use_stall), 32'(st));
        chk("bubble_ex", 32'(bubble_ex), 32'(st));
        for (int i = 0; i < NS; i++) begin
            int            es = 0;
            logic [DW-1:0] ed = '0;
            logic [AW-1:0] a  = ex_src_addr[i*AW +: AW];
            if (ex_src_valid[i]) begin
                if (mem_load_regfile && mem_dest == a) begin es = 1; ed = mem_data; end
                else if (wb_load_regfile && wb_dest == a) begin es = 2; ed = wb_data; end
                else
                    for (int k = 0; k < HD; k++)
                        if (es == 0 && mh[k].v && mh[k].dest == a) begin
                            es = 3 + k; ed = mh[k].data;
                        end
            end
            chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i*SW +: SW]), 32'(es));
            if (es != 0)
                chk($sformatf("fwd_data[%0d]", i), 32'(fwd_data[i*DW +: DW]), 32'(ed));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        bit hz;
        @(posedge clk);
        hz = model_hazard();
        if (reset_n && !stall_in) begin
            if (mbusy > 0) mbusy--;
            else if (hz) mbusy = LL - 1;
            mh.push_front('{wb_load_regfile, wb_dest, wb_data});
            void'(mh.pop_back());
        end
        #1;
    endtask

    task automatic idle();
        stall_in = 0; id_src_addr = '0; id_src_valid = '0;
        ex_src_addr = '0; ex_src_valid = '0; ex_dest = '0;
        ex_load_regfile = 0; ex_is_load = 0;
        mem_dest = '0; mem_load_regfile = 0; mem_data = '0;
        wb_dest = '0; wb_load_regfile = 0; wb_data = '0;
    endtask

    task automatic set_hazard(input logic [AW-1:0] r);
        ex_is_load = 1; ex_load_regfile = 1; ex_dest = r;
        id_src_addr = {r, r}; id_src_valid = 2'b11;
    endtask

    initial begin
        idle();
        model_reset();
        // Held reset: hazard masked, MEM match still forwarded
        #2;
        set_hazard(3'd3);
        ex_src_addr[0 +: AW] = 3'd3; ex_src_valid = 2'b01;
        mem_load_regfile = 1; mem_dest = 3'd3; mem_data = 16'h5A5A;
        cyc();
        chk("rst_stall", 32'(load_use_stall), 32'd0);
        chk("rst_sel_mem", 32'(fwd_sel[0 +: SW]), 32'd1);
        tick();
        reset_n = 1;
        idle();

        // MEM beats WB for the same register
        ex_src_addr = {3'd3, 3'd3}; ex_src_valid = 2'b11;
        mem_load_regfile = 1; mem_dest = 3'd3; mem_data = 16'hAAAA;
        wb_load_regfile = 1; wb_dest = 3'd3; wb_data = 16'hBBBB;
        cyc();
        chk("mem_pri_sel", 32'(fwd_sel[0 +: SW]), 32'd1);
        chk("mem_pri_data", 32'(fwd_data[0 +: DW]), 32'hAAAA);
        tick();

        // Previous-cycle WB value comes from history entry 0
        idle(); wb_load_regfile = 1; wb_dest = 3'd5; wb_data = 16'h1234;
        cyc(); tick();
        idle(); ex_src_addr[0 +: AW] = 3'd5; ex_src_valid = 2'b01;
        cyc();
        chk("hist0_sel", 32'(fwd_sel[0 +: SW]), 32'd3);
        chk("hist0_data", 32'(fwd_data[0 +: DW]), 32'h1234);
        tick();

        // Two writes of R1: newest wins, then it ages into entry 1
        idle(); wb_load_regfile = 1; wb_dest = 3'd1; wb_data = 16'h000A;
        cyc(); tick();
        wb_data = 16'h000B;
        cyc(); tick();
        idle(); ex_src_addr[0 +: AW] = 3'd1; ex_src_valid = 2'b01;
        cyc();
        chk("newest_sel", 32'(fwd_sel[0 +: SW]), 32'd3);
        chk("newest_data", 32'(fwd_data[0 +: DW]), 32'h000B);
        tick();
        cyc();
        chk("aged_sel", 32'(fwd_sel[0 +: SW]), 32'd4);
        chk("aged_data", 32'(fwd_data[0 +: DW]), 32'h000B);
        tick();

        // Load-use with both sources matching: one 2-cycle episode
        idle(); set_hazard(3'd2);
        cyc();
        chk("lu_c1_stall", 32'(load_use_stall), 32'd1);
        chk("lu_c1_bubble", 32'(bubble_ex), 32'd1);
        tick();
        ex_is_load = 0;
        cyc();
        chk("lu_c2_stall", 32'(load_use_stall), 32'd1);
        tick();
        cyc();
        chk("lu_done", 32'(load_use_stall), 32'd0);
        tick();

        // Frozen hazard in IDLE, then a freeze inside LU_STALL
        idle(); set_hazard(3'd2); stall_in = 1;
        cyc();
        chk("frz_idle_stall", 32'(load_use_stall), 32'd1);
        tick();
        stall_in = 0;
        cyc();
        chk("frz_start", 32'(load_use_stall), 32'd1);
        tick();
        idle(); stall_in = 1;
        wb_load_regfile = 1; wb_dest = 3'd6; wb_data = 16'h6666;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("frz_mid%0d", c), 32'(load_use_stall), 32'd1);
            tick();
        end
        idle(); ex_src_addr[0 +: AW] = 3'd6; ex_src_valid = 2'b01;
        cyc();
        chk("frz_last", 32'(load_use_stall), 32'd1);
        chk("frz_hist_held", 32'(fwd_sel[0 +: SW]), 32'd0);
        tick();
        cyc();
        chk("frz_done", 32'(load_use_stall), 32'd0);
        tick();

        // Reset in the middle of LU_STALL
        idle(); set_hazard(3'd4);
        wb_load_regfile = 1; wb_dest = 3'd7; wb_data = 16'h7777;
        cyc(); tick();
        idle(); ex_src_addr[0 +: AW] = 3'd7; ex_src_valid = 2'b01;
        cyc();
        chk("pre_rst_sel", 32'(fwd_sel[0 +: SW]), 32'd3);
        chk("pre_rst_data", 32'(fwd_data[0 +: DW]), 32'h7777);
        chk("pre_rst_stall", 32'(load_use_stall), 32'd1);
        #1;
        set_hazard(3'd4);
        reset_n = 0;
        model_reset();
        #1;
        chk("in_rst_stall", 32'(load_use_stall), 32'd0);
        chk("in_rst_bubble", 32'(bubble_ex), 32'd0);
        chk("in_rst_hist", 32'(fwd_sel[0 +: SW]), 32'd0);
        wb_load_regfile = 1; wb_dest = 3'd4; wb_data = 16'h4444;
        ex_src_addr[AW +: AW] = 3'd4; ex_src_valid = 2'b11;
        #1;
        chk("in_rst_wb_sel", 32'(fwd_sel[AW*0 + SW +: SW]), 32'd2);
        model_check();
        tick();
        reset_n = 1;
        idle(); ex_src_addr[0 +: AW] = 3'd7; ex_src_valid = 2'b01;
        cyc();
        chk("post_rst_stall", 32'(load_use_stall), 32'd0);
        chk("post_rst_sel", 32'(fwd_sel[0 +: SW]), 32'd0);
        tick();

        // Random traffic over a small register window to provoke matches
        for (int n = 0; n < 400; n++) begin
            stall_in = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NS; i++) begin
                id_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
                ex_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
            end
            id_src_valid = NS'($urandom);
            ex_src_valid = NS'($urandom);
            ex_dest = AW'($urandom_range(0, 3));
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_load_regfile = ($urandom_range(0, 3) != 0);
            mem_dest = AW'($urandom_range(0, 3));
            mem_load_regfile = ($urandom_range(0, 2) == 0);
            mem_data = DW'($urandom);
            wb_dest = AW'($urandom_range(0, 3));
            wb_load_regfile = ($urandom_range(0, 1) == 0);
            wb_data = DW'($urandom);
            cyc();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
